// File: rtl/cpu_checker_ex_pkg.sv
// Shared types and constants for the CPU trace-line checker.
// Holds the FSM state encoding, format codes, delimiter characters and range helpers.
package cpu_checker_ex_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_TIME = 4'd1,
    ST_PC   = 4'd2,
    ST_SP1  = 4'd3,
    ST_GRF  = 4'd4,
    ST_ADDR = 4'd5,
    ST_SP2  = 4'd6,
    ST_LT   = 4'd7,
    ST_SP3  = 4'd8,
    ST_DATA = 4'd9,
    ST_DONE = 4'd10
  } state_t;

  localparam logic [1:0] FMT_NONE = 2'b00;
  localparam logic [1:0] FMT_REG  = 2'b01;
  localparam logic [1:0] FMT_MEM  = 2'b10;

  localparam logic [7:0] CH_CARET  = 8'h5e;
  localparam logic [7:0] CH_AT     = 8'h40;
  localparam logic [7:0] CH_COLON  = 8'h3a;
  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2a;
  localparam logic [7:0] CH_LT     = 8'h3c;
  localparam logic [7:0] CH_EQ     = 8'h3d;
  localparam logic [7:0] CH_HASH   = 8'h23;
  localparam logic [7:0] CH_SPACE  = 8'h20;

  // Bounds arrive as arguments so a zero lower bound is not a constant compare.
  function automatic logic in_window(input logic [31:0] x,
                                     input logic [31:0] lo,
                                     input logic [31:0] hi);
    return (x >= lo) && (x <= hi);
  endfunction

  function automatic logic word_aligned(input logic [31:0] x);
    return x[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/cpu_checker_ex_char_class.sv
// Classifies one ASCII character as decimal digit / lowercase hex digit.
// Produces the digit's value; uppercase hex is deliberately not recognised.
module cpu_checker_ex_char_class (
  input  logic [7:0] char_data,
  output logic       is_dec,
  output logic       is_hex,
  output logic [3:0] nibble
);

  logic is_lower;

  always_comb begin
    is_dec   = (char_data >= 8'h30) && (char_data <= 8'h39);
    is_lower = (char_data >= 8'h61) && (char_data <= 8'h66);
    is_hex   = is_dec || is_lower;
    if (is_dec)        nibble = char_data[3:0];
    else if (is_lower) nibble = char_data[3:0] + 4'd9;
    else               nibble = 4'd0;
  end

endmodule

// File: rtl/cpu_checker_ex.sv
// Streaming checker for "^time@pc: $grf <= data#" / "^time@pc: *addr <= data#" lines.
// One char per accepted cycle; results are valid for exactly one accepted-char window.
//
// state   | meaning
// IDLE    | waiting for '^'
// TIME    | collecting decimal <time>
// PC      | collecting hex <pc>
// SP1     | after ':', spaces until '$' or '*'
// GRF     | collecting decimal register number
// ADDR    | collecting hex memory address
// SP2     | spaces before '<'
// LT      | saw '<', expecting '='
// SP3     | spaces before data
// DATA    | collecting hex data
// DONE    | line complete, outputs valid
module cpu_checker_ex
  import cpu_checker_ex_pkg::*;
#(
  parameter int          TIME_DIGITS = 4,
  parameter int          GRF_DIGITS  = 4,
  parameter int          HEX_DIGITS  = 8,
  parameter int          NUM_GRF     = 32,
  parameter logic [31:0] PC_LO       = 32'h3000,
  parameter logic [31:0] PC_HI       = 32'h4fff,
  parameter logic [31:0] ADDR_LO     = 32'h0000,
  parameter logic [31:0] ADDR_HI     = 32'h2fff,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             char_valid,
  input  logic [7:0]       char_data,
  input  logic [15:0]      freq,
  output logic [1:0]       format_type,
  output logic [3:0]       error_code,
  output logic [CNT_W-1:0] line_count
);

  localparam int TW   = $clog2(10 ** TIME_DIGITS);
  localparam int GW   = $clog2(10 ** GRF_DIGITS);
  localparam int HW   = 4 * HEX_DIGITS;
  localparam int MAXD = (HEX_DIGITS > TIME_DIGITS) ?
                        ((HEX_DIGITS > GRF_DIGITS) ? HEX_DIGITS : GRF_DIGITS) :
                        ((TIME_DIGITS > GRF_DIGITS) ? TIME_DIGITS : GRF_DIGITS);
  localparam int CW   = $clog2(MAXD + 1);
  localparam int EW   = (TW > 16) ? TW : 16;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]   t_q, t_d;
  logic [GW-1:0]   grf_q, grf_d;
  logic [HW-1:0]   pc_q, pc_d, addr_q, addr_d;
  logic            mem_q, mem_d;
  logic            is_dec, is_hex;
  logic [3:0]      nibble;

  cpu_checker_ex_char_class u_char_class (
    .char_data (char_data),
    .is_dec    (is_dec),
    .is_hex    (is_hex),
    .nibble    (nibble)
  );

  logic time_full, grf_full, hex_full, hex_exact, cnt_nz;
  assign time_full = cnt_q >= CW'(TIME_DIGITS);
  assign grf_full  = cnt_q >= CW'(GRF_DIGITS);
  assign hex_full  = cnt_q >= CW'(HEX_DIGITS);
  assign hex_exact = cnt_q == CW'(HEX_DIGITS);
  assign cnt_nz    = cnt_q != '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    t_d     = t_q;
    grf_d   = grf_q;
    pc_d    = pc_q;
    addr_d  = addr_q;
    mem_d   = mem_q;
    if (char_data == CH_CARET) begin
      // resync: a caret always restarts a line, whatever came before
      state_d = ST_TIME;
      cnt_d   = '0;
      t_d     = '0;
      grf_d   = '0;
      pc_d    = '0;
      addr_d  = '0;
      mem_d   = 1'b0;
    end else begin
      state_d = ST_IDLE;
      case (state_q)
        ST_TIME:
          if (is_dec && !time_full) begin
            state_d = ST_TIME;
            t_d     = t_q * TW'(10) + TW'(nibble);
            cnt_d   = cnt_q + 1'b1;
          end else if (char_data == CH_AT && cnt_nz) begin
            state_d = ST_PC;
            cnt_d   = '0;
          end
        ST_PC:
          if (is_hex && !hex_full) begin
            state_d = ST_PC;
            pc_d    = {pc_q[HW-5:0], nibble};
            cnt_d   = cnt_q + 1'b1;
          end else if (char_data == CH_COLON && hex_exact) begin
            state_d = ST_SP1;
            cnt_d   = '0;
          end
        ST_SP1:
          if (char_data == CH_SPACE) state_d = ST_SP1;
          else if (char_data == CH_DOLLAR) begin
            state_d = ST_GRF;
            mem_d   = 1'b0;
          end else if (char_data == CH_STAR) begin
            state_d = ST_ADDR;
            mem_d   = 1'b1;
          end
        ST_GRF:
          if (is_dec && !grf_full) begin
            state_d = ST_GRF;
            grf_d   = grf_q * GW'(10) + GW'(nibble);
            cnt_d   = cnt_q + 1'b1;
          end else if (char_data == CH_SPACE && cnt_nz) state_d = ST_SP2;
          else if (char_data == CH_LT && cnt_nz) state_d = ST_LT;
        ST_ADDR:
          if (is_hex && !hex_full) begin
            state_d = ST_ADDR;
            addr_d  = {addr_q[HW-5:0], nibble};
            cnt_d   = cnt_q + 1'b1;
          end else if (char_data == CH_SPACE && hex_exact) state_d = ST_SP2;
          else if (char_data == CH_LT && hex_exact) state_d = ST_LT;
        ST_SP2:
          if (char_data == CH_SPACE) state_d = ST_SP2;
          else if (char_data == CH_LT) state_d = ST_LT;
        ST_LT:
          if (char_data == CH_EQ) state_d = ST_SP3;
        ST_SP3:
          if (char_data == CH_SPACE) state_d = ST_SP3;
          else if (is_hex) begin
            state_d = ST_DATA;
            cnt_d   = CW'(1);
          end
        ST_DATA:
          if (is_hex && !hex_full) begin
            state_d = ST_DATA;
            cnt_d   = cnt_q + 1'b1;
          end else if (char_data == CH_HASH && hex_exact) state_d = ST_DONE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      t_q        <= '0;
      grf_q      <= '0;
      pc_q       <= '0;
      addr_q     <= '0;
      mem_q      <= 1'b0;
      line_count <= '0;
    end else if (char_valid) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      t_q     <= t_d;
      grf_q   <= grf_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      mem_q   <= mem_d;
      if (state_d == ST_DONE && line_count != '1)
        line_count <= line_count + 1'b1;
    end
  end

  logic [EW-1:0] half, t_ext, divisor;
  logic          done, time_err, pc_err, addr_err, grf_err;

  assign done     = state_q == ST_DONE;
  assign half     = EW'(freq >> 1);
  assign t_ext    = EW'(t_q);
  assign divisor  = (half == '0) ? EW'(1) : half;
  assign time_err = (half == '0) || ((t_ext % divisor) != '0);
  assign pc_err   = !in_window(32'(pc_q), PC_LO, PC_HI) || !word_aligned(32'(pc_q));
  assign addr_err = mem_q && (!in_window(32'(addr_q), ADDR_LO, ADDR_HI) ||
                              !word_aligned(32'(addr_q)));
  assign grf_err  = !mem_q && (grf_q >= GW'(NUM_GRF));

  assign format_type = done ? (mem_q ? FMT_MEM : FMT_REG) : FMT_NONE;
  assign error_code  = done ? {grf_err, addr_err, pc_err, time_err} : 4'b0000;

endmodule
